// File: rtl/vc_arbiter_ctrl.sv
// ============================================================================
// Module  : vc_arbiter_ctrl
// Brief   : VC0/VC1 transmit FIFO controller. Handles FIFO bring-up,
//           threshold latching and priority arbitration with a VC1
//           starvation guard, and routes each word to destination D0 or D1.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module vc_arbiter_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_vc_in,
  input  logic [3:0]            umbral_d_in,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic [DATA_WIDTH-1:0] data_vc0,
  input  logic [DATA_WIDTH-1:0] data_vc1,
  input  logic                  afull_d0,
  input  logic                  afull_d1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [3:0]            umbral_vc,
  output logic [3:0]            umbral_d,
  output logic                  fifo_init,
  output logic [1:0]            state,
  output logic                  idle
);

  localparam int                 C_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [C_CNT_W-1:0] C_MAX   = C_CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [C_CNT_W-1:0]      r_starve;
  logic                    r_vld_q;
  logic                    r_sel_q;
  logic                    r_push_d0;
  logic                    r_push_d1;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [3:0]              r_umbral_vc;
  logic [3:0]              r_umbral_d;
  logic                    w_pop0;
  logic                    w_pop1;
  logic                    w_blocked;
  logic                    w_flush;
  logic [DATA_WIDTH-1:0]   w_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_INIT;
      ST_INIT:   if (!init) w_next = ST_IDLE;
      ST_IDLE: begin
        if (init)                       w_next = ST_INIT;
        else if (!empty_vc0 || !empty_vc1) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                                 w_next = ST_INIT;
        else if (empty_vc0 && empty_vc1 && !r_vld_q) w_next = ST_IDLE;
      end
      default:   w_next = ST_RESET;
    endcase
  end

  // Strict VC0 priority unless VC1 has waited MAX_BURST VC0 grants.
  assign w_blocked = afull_d0 | afull_d1;

  always_comb begin
    w_pop0 = 1'b0;
    w_pop1 = 1'b0;
    if (r_state == ST_ACTIVE && !w_blocked) begin
      if (r_starve == C_MAX && !empty_vc1) w_pop1 = 1'b1;
      else if (!empty_vc0)                 w_pop0 = 1'b1;
      else if (!empty_vc1)                 w_pop1 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_starve <= '0;
    else if (empty_vc1 || w_pop1)    r_starve <= '0;
    else if (w_pop0 && r_starve != C_MAX) r_starve <= r_starve + C_CNT_W'(1);
  end

  // FIFO data is valid one cycle after the pop; words in flight die on INIT entry.
  assign w_flush = (w_next == ST_INIT);
  assign w_word  = r_sel_q ? data_vc1 : data_vc0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_q   <= 1'b0;
      r_sel_q   <= 1'b0;
      r_push_d0 <= 1'b0;
      r_push_d1 <= 1'b0;
      r_data    <= '0;
    end else if (w_flush) begin
      r_vld_q   <= 1'b0;
      r_push_d0 <= 1'b0;
      r_push_d1 <= 1'b0;
    end else begin
      r_vld_q   <= w_pop0 | w_pop1;
      r_sel_q   <= w_pop1;
      r_push_d0 <= r_vld_q & ~w_word[DATA_WIDTH-1];
      r_push_d1 <= r_vld_q &  w_word[DATA_WIDTH-1];
      if (r_vld_q) r_data <= w_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_umbral_vc <= '0;
      r_umbral_d  <= '0;
    end else if (r_state == ST_INIT) begin
      r_umbral_vc <= umbral_vc_in;
      r_umbral_d  <= umbral_d_in;
    end
  end

  assign pop_vc0   = w_pop0;
  assign pop_vc1   = w_pop1;
  assign push_d0   = r_push_d0;
  assign push_d1   = r_push_d1;
  assign data_out  = r_data;
  assign umbral_vc = r_umbral_vc;
  assign umbral_d  = r_umbral_d;
  assign state     = r_state;
  assign idle      = (r_state == ST_IDLE);
  assign fifo_init = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_vc_arbiter_ctrl.sv
// ============================================================================
// Module  : tb_vc_arbiter_ctrl
// Brief   : Directed bench for vc_arbiter_ctrl with a behavioural VC FIFO model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vc_arbiter_ctrl;

  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] umbral_vc_in, umbral_d_in;
  logic       empty_vc0, empty_vc1;
  logic [5:0] data_vc0, data_vc1;
  logic       afull_d0, afull_d1;
  logic       pop_vc0, pop_vc1, push_d0, push_d1;
  logic [5:0] data_out;
  logic [3:0] umbral_vc, umbral_d;
  logic       fifo_init;
  logic [1:0] state;
  logic       idle;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         grant_q[$];
  int         grant_cyc_q[$];
  int         push_data_q[$];
  int         push_dst_q[$];
  int         push_cyc_q[$];

  vc_arbiter_ctrl #(.DATA_WIDTH(6), .MAX_BURST(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_vc_in (umbral_vc_in),
    .umbral_d_in  (umbral_d_in),
    .empty_vc0    (empty_vc0),
    .empty_vc1    (empty_vc1),
    .data_vc0     (data_vc0),
    .data_vc1     (data_vc1),
    .afull_d0     (afull_d0),
    .afull_d1     (afull_d1),
    .pop_vc0      (pop_vc0),
    .pop_vc1      (pop_vc1),
    .push_d0      (push_d0),
    .push_d1      (push_d1),
    .data_out     (data_out),
    .umbral_vc    (umbral_vc),
    .umbral_d     (umbral_d),
    .fifo_init    (fifo_init),
    .state        (state),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    grant_q.delete(); grant_cyc_q.delete();
    push_data_q.delete(); push_dst_q.delete(); push_cyc_q.delete();
  endtask

  task automatic clear_fifos();
    q0.delete(); q1.delete();
    empty_vc0 = 1'b1; empty_vc1 = 1'b1;
  endtask

  // One clock: record grants/pushes, advance the FIFO model after the edge.
  task automatic tick();
    logic p0, p1;
    chk("pop_excl", {31'd0, pop_vc0 & pop_vc1}, 32'd0);
    chk("push_excl", {31'd0, push_d0 & push_d1}, 32'd0);
    p0 = pop_vc0;
    p1 = pop_vc1;
    if (p0) begin grant_q.push_back(0); grant_cyc_q.push_back(cyc); end
    if (p1) begin grant_q.push_back(1); grant_cyc_q.push_back(cyc); end
    if (push_d0 || push_d1) begin
      push_data_q.push_back(int'(data_out));
      push_dst_q.push_back(push_d1 ? 1 : 0);
      push_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) data_vc0 = q0.pop_front();
    if (p1 && q1.size() > 0) data_vc1 = q1.pop_front();
    empty_vc0 = (q0.size() == 0);
    empty_vc1 = (q1.size() == 0);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp_g[12] = '{0,0,0,0,1,0,0,0,0,1,0,0};
  int n0, n1, exp_d, obs_i;

  initial begin
    reset = 1'b0; init = 1'b0;
    umbral_vc_in = 4'd0; umbral_d_in = 4'd0;
    empty_vc0 = 1'b1; empty_vc1 = 1'b1;
    data_vc0 = '0; data_vc1 = '0;
    afull_d0 = 1'b0; afull_d1 = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_idle", idle, 0);
    chk("rst_fifo_init", fifo_init, 0);
    chk("rst_pops", {pop_vc1, pop_vc0}, 0);
    chk("rst_push", {push_d1, push_d0}, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_umbral", {umbral_vc, umbral_d}, 0);

    @(posedge clk); #2;
    reset = 1'b1;
    tick();
    chk("to_init_state", state, 1);
    chk("init_fifo_init", fifo_init, 0);

    // T2: threshold latching
    init = 1'b1; umbral_vc_in = 4'd3; umbral_d_in = 4'd2;
    run(3);
    chk("t2_in_init", state, 1);
    init = 1'b0;
    tick();
    chk("t2_umbral_vc", umbral_vc, 3);
    chk("t2_umbral_d", umbral_d, 2);
    chk("t2_state", state, 2);
    chk("t2_idle", idle, 1);
    chk("t2_fifo_init", fifo_init, 1);
    chk("t2_idle_no_pop", {pop_vc1, pop_vc0}, 0);

    // T3: starvation guard ordering and pop->push latency
    clear_rec();
    for (int i = 0; i < 10; i++) q0.push_back(6'h01 + 6'(i));
    for (int i = 0; i < 2; i++)  q1.push_back(6'h31 + 6'(i));
    empty_vc0 = 1'b0; empty_vc1 = 1'b0;
    #1;
    chk("t3_idle_no_pop", {pop_vc1, pop_vc0}, 0);
    run(20);
    chk("t3_grant_cnt", grant_q.size(), 12);
    chk("t3_push_cnt", push_data_q.size(), 12);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 12; k++) begin
      obs_i = (k < grant_q.size()) ? grant_q[k] : -1;
      chk($sformatf("t3_grant%0d", k), obs_i, exp_g[k]);
      if (exp_g[k] == 0) begin exp_d = 'h01 + n0; n0++; end
      else               begin exp_d = 'h31 + n1; n1++; end
      obs_i = (k < push_data_q.size()) ? push_data_q[k] : -1;
      chk($sformatf("t3_push_data%0d", k), obs_i, exp_d);
      obs_i = (k < push_dst_q.size()) ? push_dst_q[k] : -1;
      chk($sformatf("t3_push_dst%0d", k), obs_i, exp_g[k]);
    end
    obs_i = (grant_cyc_q.size() > 0 && push_cyc_q.size() > 0) ?
            push_cyc_q[0] - grant_cyc_q[0] : -1;
    chk("t3_latency", obs_i, 2);
    chk("t3_back_idle", state, 2);

    // T4: destination routing by MSB
    clear_rec();
    q0.push_back(6'b100101); q0.push_back(6'b000011);
    empty_vc0 = 1'b0;
    #1;
    run(8);
    chk("t4_push_cnt", push_data_q.size(), 2);
    obs_i = (push_data_q.size() > 0) ? push_data_q[0] : -1;
    chk("t4_first_data", obs_i, 'h25);
    obs_i = (push_dst_q.size() > 0) ? push_dst_q[0] : -1;
    chk("t4_first_dst", obs_i, 1);
    obs_i = (push_data_q.size() > 1) ? push_data_q[1] : -1;
    chk("t4_second_data", obs_i, 'h03);
    obs_i = (push_dst_q.size() > 1) ? push_dst_q[1] : -1;
    chk("t4_second_dst", obs_i, 0);
    obs_i = (push_cyc_q.size() > 1) ? push_cyc_q[1] - push_cyc_q[0] : -1;
    chk("t4_back_to_back", obs_i, 1);
    chk("t4_data_hold", data_out, 6'h03);

    // T5: back-pressure
    clear_rec();
    for (int i = 0; i < 6; i++) q0.push_back(6'h01 + 6'(i));
    for (int i = 0; i < 6; i++) q1.push_back(6'h21 + 6'(i));
    empty_vc0 = 1'b0; empty_vc1 = 1'b0;
    #1;
    tick();
    chk("t5_active", state, 3);
    chk("t5_pop_a", pop_vc0, 1);
    run(2);
    afull_d0 = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_blocked%0d", i), {pop_vc1, pop_vc0}, 0);
      tick();
    end
    chk("t5_grants_before", grant_q.size(), 2);
    chk("t5_inflight_pushed", push_data_q.size(), 2);
    obs_i = (push_data_q.size() > 1) ? push_data_q[1] : -1;
    chk("t5_inflight_data", obs_i, 'h02);
    afull_d0 = 1'b0;
    #1;
    chk("t5_resume", pop_vc0, 1);
    run(40);
    chk("t5_drained_pushes", push_data_q.size(), 12);
    chk("t5_idle", state, 2);

    // T6: init while ACTIVE with a word in flight
    clear_rec();
    q0.push_back(6'h0A); q0.push_back(6'h0B); q0.push_back(6'h0C);
    empty_vc0 = 1'b0;
    #1;
    run(2);
    init = 1'b1;
    #1;
    tick();
    chk("t6_state", state, 1);
    chk("t6_pops", {pop_vc1, pop_vc0}, 0);
    chk("t6_push", {push_d1, push_d0}, 0);
    chk("t6_fifo_init", fifo_init, 0);
    clear_fifos();
    run(3);
    chk("t6_no_push", push_data_q.size(), 0);
    init = 1'b0;
    tick();
    chk("t6_idle", state, 2);

    // T1: async reset mid-ACTIVE
    q0.push_back(6'h11); q0.push_back(6'h12); q0.push_back(6'h13); q0.push_back(6'h14);
    empty_vc0 = 1'b0;
    #1;
    run(3);
    chk("t1_push_before", push_d0, 1);
    reset = 1'b0;
    #1;
    chk("t1_state", state, 0);
    chk("t1_idle", idle, 0);
    chk("t1_fifo_init", fifo_init, 0);
    chk("t1_pops", {pop_vc1, pop_vc0}, 0);
    chk("t1_push", {push_d1, push_d0}, 0);
    chk("t1_data_out", data_out, 0);
    chk("t1_umbral", {umbral_vc, umbral_d}, 0);
    clear_fifos();
    run(2);
    chk("t1_held", state, 0);
    reset = 1'b1;
    clear_rec();
    run(5);
    chk("t1_no_push_after", push_data_q.size(), 0);
    chk("t1_final_idle", state, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
